// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch sequencer: drives the PC register load and the instruction
// memory request/ack handshake, and holds one fetched instruction for IF/ID.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t      state;
  logic        kill;
  logic [7:0]  tmo_cnt;
  logic        in_req;
  logic        timeout;
  logic        flush;
  logic        take;
  logic [31:0] target;
  logic [31:0] reissue_addr;

  assign in_req  = (state == REQ);
  assign timeout = in_req & ~imem_ack & (tmo_cnt == 8'(TIMEOUT - 1));
  assign flush   = exc_valid | redirect_valid | timeout;
  assign take    = in_req & imem_ack & ~kill & ~flush;

  always_comb begin
    target = pc_cur + 32'd4;
    if (exc_valid | timeout) target = EXC_VECTOR;
    else if (redirect_valid) target = redirect_target;
  end

  assign pc_next      = target & ~32'h3;
  assign pc_ena       = ~rst & (flush | take);
  // Address for a freshly issued request: the value the PC is about to take.
  assign reissue_addr = pc_ena ? pc_next : pc_cur;

  assign imem_req  = in_req;
  assign fetch_err = timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      kill      <= 1'b0;
      tmo_cnt   <= 8'd0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_inst   <= 32'd0;
      if_pc     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_addr <= reissue_addr;
          tmo_cnt   <= 8'd0;
        end
        REQ: begin
          if (imem_ack) begin
            if (take) begin
              if_inst  <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
              state    <= FULL;
            end else begin
              kill      <= 1'b0;
              imem_addr <= reissue_addr;
              tmo_cnt   <= 8'd0;
            end
          end else if (timeout) begin
            // Abandon the request; the memory drops it on re-issue.
            kill      <= 1'b0;
            imem_addr <= reissue_addr;
            tmo_cnt   <= 8'd0;
          end else begin
            if (flush) kill <= 1'b1;
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        FULL: begin
          if (flush || !stall) begin
            if_valid  <= 1'b0;
            state     <= REQ;
            imem_addr <= reissue_addr;
            tmo_cnt   <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized + directed bench for pc_fetch_ctrl against a cycle-level
// behavioural model of the fetch rules, with a PC register and memory model.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] EXC = 32'h0040_0004;
  localparam int          TMO = 16;

  logic        clk, rst;
  logic [31:0] pc_cur, pc_next, imem_addr, imem_rdata, if_inst, if_pc, redirect_target;
  logic        pc_ena, imem_req, imem_ack, if_valid, stall, redirect_valid, exc_valid, fetch_err;

  pc_fetch_ctrl #(.RESET_PC(RPC), .EXC_VECTOR(EXC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_ena(pc_ena), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  bit          m_started, m_holding, m_kill;
  int          m_waited;
  logic [31:0] m_addr, m_pc, m_inst, m_ipc;
  // memory model
  bit          mem_busy;
  int          mem_left, lat_lo, lat_hi;
  logic [31:0] mem_addr;
  // observations for directed checks
  logic        obs_ferr;
  logic [31:0] obs_next, obs_take_next;
  logic [31:0] if_pc_log[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_started = 0; m_holding = 0; m_kill = 0; m_waited = 0;
    m_addr = RPC; m_pc = RPC; m_inst = 32'd0; m_ipc = 32'd0;
    mem_busy = 0; mem_left = 0; mem_addr = 32'd0;
    pc_cur = RPC;
  endtask

  task automatic chk_reset_outputs();
    chk1 ("rst_imem_req",  imem_req,  1'b0);
    chk32("rst_imem_addr", imem_addr, RPC);
    chk1 ("rst_if_valid",  if_valid,  1'b0);
    chk32("rst_if_inst",   if_inst,   32'd0);
    chk32("rst_if_pc",     if_pc,     32'd0);
    chk1 ("rst_fetch_err", fetch_err, 1'b0);
    chk1 ("rst_pc_ena",    pc_ena,    1'b0);
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic step(input bit rv, input logic [31:0] rt, input bit ev, input bit st);
    bit req_now, ack, tmo, fl, take, ena, nreq;
    logic [31:0] nxt, rd;
    req_now = m_started && !m_holding;
    ack = 0;
    rd  = $urandom;
    if (req_now && !mem_busy) begin
      mem_busy = 1; mem_addr = m_addr; mem_left = int'($urandom_range(lat_hi, lat_lo));
    end
    if (mem_busy) begin
      if (mem_left == 0) begin ack = 1; rd = rdata_of(mem_addr); mem_busy = 0; end
      else mem_left--;
    end
    imem_ack = ack; imem_rdata = rd; stall = st;
    redirect_valid = rv; redirect_target = rt; exc_valid = ev;
    #1;
    tmo  = req_now && !ack && (m_waited == TMO - 1);
    fl   = ev || rv || tmo;
    take = req_now && ack && !m_kill && !fl;
    ena  = fl || take;
    nxt  = (ev || tmo) ? EXC : (rv ? (rt & ~32'h3) : m_pc + 32'd4);
    chk1("imem_req", imem_req, req_now);
    chk1("if_valid", if_valid, m_holding);
    chk1("pc_ena", pc_ena, ena);
    chk1("fetch_err", fetch_err, tmo);
    if (ena) chk32("pc_next", pc_next, nxt);
    if (req_now) chk32("imem_addr", imem_addr, m_addr);
    if (m_holding) begin
      chk32("if_inst", if_inst, m_inst);
      chk32("if_pc", if_pc, m_ipc);
    end
    obs_ferr = fetch_err;
    obs_next = pc_next;
    if (take) obs_take_next = pc_next;
    if (m_holding && !st && !fl) if_pc_log.push_back(if_pc);
    nreq = 0;
    if (!m_started) begin
      m_started = 1; nreq = 1;
    end else if (req_now) begin
      if (ack) begin
        if (take) begin m_holding = 1; m_inst = rd; m_ipc = m_addr; end
        else begin m_kill = 0; nreq = 1; end
      end else if (tmo) begin
        m_kill = 0; nreq = 1; mem_busy = 0;
      end else begin
        if (fl) m_kill = 1;
        m_waited++;
      end
    end else if (fl || !st) begin
      m_holding = 0; nreq = 1;
    end
    if (nreq) begin m_addr = ena ? nxt : m_pc; m_waited = 0; end
    if (ena) m_pc = nxt;
    @(posedge clk); #1;
    pc_cur = m_pc;
  endtask

  task automatic wait_full(input bit st);
    int n;
    n = 0;
    while (!m_holding && n < 30) begin step(0, 32'd0, 0, st); n++; end
    chk1("wait_full", if_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 0; imem_rdata = 0; stall = 0;
    redirect_valid = 1; redirect_target = 32'h0040_0100; exc_valid = 1;
    pc_cur = RPC;
    lat_lo = 1; lat_hi = 1;
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;

    // sequential fetch, 1-cycle memory
    repeat (12) step(0, 32'd0, 0, 0);
    chk1("ifpc_count", if_pc_log.size() >= 3, 1'b1);
    if (if_pc_log.size() >= 3) begin
      chk32("ifpc_0", if_pc_log[0], 32'h0040_0000);
      chk32("ifpc_1", if_pc_log[1], 32'h0040_0004);
      chk32("ifpc_2", if_pc_log[2], 32'h0040_0008);
    end

    // stall held in FULL, then release
    wait_full(1);
    repeat (5) step(0, 32'd0, 0, 1);
    lat_lo = 3; lat_hi = 3;
    step(0, 32'd0, 0, 0);
    chk1("req_after_release", imem_req, 1'b1);

    // redirect while waiting for a 3-cycle ack
    step(1, 32'h0040_0100, 0, 0);
    chk32("redir_next", obs_next, 32'h0040_0100);
    repeat (3) step(0, 32'd0, 0, 0);
    chk32("redir_addr", imem_addr, 32'h0040_0100);
    chk1("redir_discard", if_valid, 1'b0);

    // exception + redirect together in FULL
    lat_lo = 1; lat_hi = 1;
    wait_full(1);
    lat_lo = 100; lat_hi = 100;
    step(1, 32'h0040_0200, 1, 1);
    chk32("exc_next", obs_next, EXC);
    chk1("exc_clear", if_valid, 1'b0);
    chk32("exc_addr", imem_addr, EXC);

    // memory never answers: timeout on the 16th REQ cycle
    for (int i = 1; i <= TMO; i++) begin
      step(0, 32'd0, 0, 0);
      chk1("ferr_cycle", obs_ferr, i == TMO);
    end
    lat_lo = 1; lat_hi = 1;
    chk32("tmo_refetch_addr", imem_addr, EXC);
    chk1("tmo_refetch_req", imem_req, 1'b1);

    // wrap at the top of the address space, then alignment
    wait_full(1);
    step(1, 32'hFFFF_FFFC, 0, 1);
    obs_take_next = 32'h1;
    wait_full(1);
    chk32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk32("wrap_next", obs_take_next, 32'h0000_0000);
    step(1, 32'h0040_0013, 0, 1);
    chk32("align_next", obs_next, 32'h0040_0010);

    // randomized traffic
    lat_lo = 0; lat_hi = 5;
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 12) == 0, $urandom, ($urandom % 30) == 0, ($urandom % 3) == 0);
    end

    // asynchronous reset in the middle of a request
    lat_lo = 4; lat_hi = 4;
    begin
      int n;
      n = 0;
      while (!(m_started && !m_holding) && n < 30) begin step(0, 32'd0, 0, 0); n++; end
    end
    step(0, 32'd0, 0, 0);
    chk1("mid_req", imem_req, 1'b1);
    redirect_valid = 1; exc_valid = 1;
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    lat_lo = 1; lat_hi = 2;
    repeat (10) step(0, 32'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
